// File: rtl/upsampler_poly.sv
// Polyphase interpolating FIR: one input symbol fans out into L output
// phases, each phase using every L-th coefficient. Products are registered
// in the strobe cycle and summed, shifted and saturated one clock later.
module upsampler_poly #(
  parameter  int DW        = 18,
  parameter  int CW        = 18,
  parameter  int L         = 4,
  parameter  int TPP       = 5,
  parameter  int OUT_SHIFT = 17,
  localparam int N         = L * TPP,
  localparam int AW        = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sym_clk_ena,
  input  logic                 sam_clk_ena,
  input  logic signed [DW-1:0] x_in,
  input  logic                 bypass,
  input  logic                 coef_wr_en,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic signed [DW-1:0] y,
  output logic                 y_valid,
  output logic                 ovf
);

  localparam int PHW  = $clog2(L);
  localparam int PW   = DW + CW;
  localparam int ACCW = DW + CW + $clog2(TPP);

  localparam logic [AW:0] NLIM = (AW + 1)'(N);
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  // Filter state
  logic signed [DW-1:0] r_x [TPP];
  logic [PHW-1:0]       r_p;
  logic signed [CW-1:0] r_h [N];

  // Product stage
  logic signed [PW-1:0] r_prod [TPP];
  logic                 r_s1Valid;
  logic                 r_s1Bypass;
  logic signed [DW-1:0] r_s1X0;

  // Output stage
  logic signed [DW-1:0] r_y;
  logic                 r_ovf;
  logic                 r_yValid;

  // Combinational view of the current strobe
  logic signed [DW-1:0]   w_xEff [TPP];
  logic [PHW-1:0]         w_phase;
  logic signed [CW-1:0]   w_hSel [TPP];
  logic signed [PW-1:0]   w_prod [TPP];
  logic signed [ACCW-1:0] w_acc;
  logic signed [ACCW-1:0] w_shifted;
  logic signed [DW-1:0]   w_sat;
  logic                   w_clip;

  // A coincident symbol makes this strobe see the shifted line and phase 0
  always_comb begin
    w_xEff[0] = sym_clk_ena ? x_in : r_x[0];
    for (int k = 1; k < TPP; k++) begin
      w_xEff[k] = sym_clk_ena ? r_x[k-1] : r_x[k];
    end
    w_phase = sym_clk_ena ? '0 : r_p;
  end

  // Pick coefficient h[k*L + phase] for every tap (pre-write value)
  always_comb begin
    for (int k = 0; k < TPP; k++) begin
      w_hSel[k] = r_h[AW'(k * L) + AW'(w_phase)];
    end
  end

  // Full-precision signed products, one per tap
  always_comb begin
    for (int k = 0; k < TPP; k++) begin
      w_prod[k] = PW'(w_hSel[k]) * PW'(w_xEff[k]);
    end
  end

  // Sum registered products, floor-shift, then clip to the output range
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < TPP; k++) begin
      w_acc = w_acc + ACCW'(r_prod[k]);
    end
    w_shifted = w_acc >>> OUT_SHIFT;
    w_sat     = w_shifted[DW-1:0];
    w_clip    = 1'b0;
    if (w_shifted > MAXV) begin
      w_sat  = MAXV[DW-1:0];
      w_clip = 1'b1;
    end else if (w_shifted < MINV) begin
      w_sat  = MINV[DW-1:0];
      w_clip = 1'b1;
    end
  end

  // Delay line, phase counter and coefficient memory
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TPP; k++) r_x[k] <= '0;
      for (int i = 0; i < N; i++) r_h[i] <= '0;
      r_p <= '0;
    end else begin
      if (sym_clk_ena) begin
        r_x[0] <= x_in;
        for (int k = 1; k < TPP; k++) r_x[k] <= r_x[k-1];
      end
      if (sym_clk_ena) begin
        r_p <= sam_clk_ena ? PHW'(1) : '0;
      end else if (sam_clk_ena) begin
        r_p <= (r_p == PHW'(L - 1)) ? '0 : r_p + 1'b1;
      end
      if (coef_wr_en && ({1'b0, coef_addr} < NLIM)) begin
        r_h[coef_addr] <= coef_data;
      end
    end
  end

  // Capture products and bypass sample for each output strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TPP; k++) r_prod[k] <= '0;
      r_s1Valid  <= 1'b0;
      r_s1Bypass <= 1'b0;
      r_s1X0     <= '0;
    end else begin
      r_s1Valid <= sam_clk_ena;
      if (sam_clk_ena) begin
        for (int k = 0; k < TPP; k++) r_prod[k] <= w_prod[k];
        r_s1Bypass <= bypass;
        r_s1X0     <= w_xEff[0];
      end
    end
  end

  // Publish the new output; y and ovf hold between valid pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y      <= '0;
      r_ovf    <= 1'b0;
      r_yValid <= 1'b0;
    end else begin
      r_yValid <= r_s1Valid;
      if (r_s1Valid) begin
        if (r_s1Bypass) begin
          r_y   <= r_s1X0;
          r_ovf <= 1'b0;
        end else begin
          r_y   <= w_sat;
          r_ovf <= w_clip;
        end
      end
    end
  end

  assign y       = r_y;
  assign ovf     = r_ovf;
  assign y_valid = r_yValid;

endmodule

// File: tb/tb_upsampler_poly.sv
// Testbench for upsampler_poly: a behavioural model computes each output
// from the filter equation, a negedge process compares every cycle, and
// directed scenarios pin known literal results.
module tb_upsampler_poly;

   localparam int DW        = 18;
   localparam int CW        = 18;
   localparam int L         = 4;
   localparam int TPP       = 5;
   localparam int OUT_SHIFT = 17;
   localparam int N         = L * TPP;
   localparam int AW        = $clog2(N);
   localparam longint MAXY  = (longint'(1) <<< (DW - 1)) - 1;
   localparam longint MINY  = -(longint'(1) <<< (DW - 1));

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 sym_clk_ena = 1'b0;
   logic                 sam_clk_ena = 1'b0;
   logic signed [DW-1:0] x_in = '0;
   logic                 bypass = 1'b0;
   logic                 coef_wr_en = 1'b0;
   logic [AW-1:0]        coef_addr = '0;
   logic signed [CW-1:0] coef_data = '0;
   logic signed [DW-1:0] y;
   logic                 y_valid;
   logic                 ovf;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Behavioural model state
   longint mh [N];
   longint mx [TPP];
   int     mp;
   bit     pendValid;
   longint pendY;
   bit     pendOvf;
   bit     expValid;
   longint expY;
   bit     expOvf;
   bit     modelReady = 1'b0;

   // Outputs collected on each valid pulse
   longint gotY [$];
   bit     gotOvf [$];
   int     gotCyc [$];

   upsampler_poly #(
      .DW(DW), .CW(CW), .L(L), .TPP(TPP), .OUT_SHIFT(OUT_SHIFT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sym_clk_ena(sym_clk_ena),
      .sam_clk_ena(sam_clk_ena),
      .x_in(x_in),
      .bypass(bypass),
      .coef_wr_en(coef_wr_en),
      .coef_addr(coef_addr),
      .coef_data(coef_data),
      .y(y),
      .y_valid(y_valid),
      .ovf(ovf)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic signed [63:0] got,
                              input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // One clock of the reference: filter equation evaluated directly
   task automatic modelStep();
      longint acc;
      longint sh;
      int     ph;
      cyc++;
      if (reset) begin
         for (int i = 0; i < N; i++) mh[i] = 0;
         for (int k = 0; k < TPP; k++) mx[k] = 0;
         mp = 0;
         pendValid = 0; pendY = 0; pendOvf = 0;
         expValid = 0; expY = 0; expOvf = 0;
         modelReady = 1'b1;
      end else begin
         expValid = pendValid;
         if (pendValid) begin
            expY   = pendY;
            expOvf = pendOvf;
         end
         if (sym_clk_ena) begin
            for (int k = TPP - 1; k > 0; k--) mx[k] = mx[k-1];
            mx[0] = x_in;
         end
         pendValid = sam_clk_ena;
         if (sam_clk_ena) begin
            ph = sym_clk_ena ? 0 : mp;
            if (bypass) begin
               pendY = mx[0];
               pendOvf = 0;
            end else begin
               acc = 0;
               for (int k = 0; k < TPP; k++) acc += mh[k*L + ph] * mx[k];
               sh = acc >>> OUT_SHIFT;
               if (sh > MAXY) begin
                  pendY = MAXY; pendOvf = 1;
               end else if (sh < MINY) begin
                  pendY = MINY; pendOvf = 1;
               end else begin
                  pendY = sh; pendOvf = 0;
               end
            end
         end
         if (sym_clk_ena) mp = sam_clk_ena ? 1 : 0;
         else if (sam_clk_ena) mp = (mp + 1) % L;
         if (coef_wr_en && (int'(coef_addr) < N)) mh[coef_addr] = coef_data;
      end
   endtask

   // Reference advances on every rising edge
   initial begin
      forever begin
         @(posedge clk);
         modelStep();
      end
   end

   // Compare DUT against the reference every cycle, away from the edge
   initial begin
      forever begin
         @(negedge clk);
         if (modelReady) begin
            checkOutput("y_valid", y_valid, expValid);
            checkOutput("y", y, expY);
            checkOutput("ovf", ovf, expOvf);
            if (y_valid === 1'b1) begin
               gotY.push_back(y);
               gotOvf.push_back(ovf);
               gotCyc.push_back(cyc);
            end
         end
      end
   end

   task automatic applyStimulus(input bit sym, input bit sam, input longint x,
                                input bit byp, input bit wr, input int addr,
                                input longint data);
      sym_clk_ena = sym;
      sam_clk_ena = sam;
      x_in        = DW'(x);
      bypass      = byp;
      coef_wr_en  = wr;
      coef_addr   = AW'(addr);
      coef_data   = CW'(data);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
   endtask

   task automatic loadBasic();
      doReset();
      applyStimulus(0, 0, 0, 0, 1, 0, 32768);
      applyStimulus(0, 0, 0, 0, 1, 1, 65536);
      applyStimulus(0, 0, 0, 0, 1, 2, 98304);
      applyStimulus(0, 0, 0, 0, 1, 3, 131071);
   endtask

   task automatic clearGot();
      gotY.delete();
      gotOvf.delete();
      gotCyc.delete();
   endtask

   // One symbol followed by n output strobes, the first coincident
   task automatic runBurst(input int n);
      applyStimulus(1, 1, 4096, 0, 0, 0, 0);
      repeat (n - 1) applyStimulus(0, 1, 0, 0, 0, 0, 0);
      idle(3);
   endtask

   task automatic checkSeq(input string name, input longint exp [], input int n);
      checkOutput({name, "_count"}, gotY.size(), n);
      for (int i = 0; i < n && i < gotY.size(); i++) begin
         checkOutput($sformatf("%s_y%0d", name, i), gotY[i], exp[i]);
         checkOutput($sformatf("%s_ovf%0d", name, i), gotOvf[i], 0);
      end
   endtask

   // Directed scenarios followed by randomized traffic
   initial begin
      longint exp [];
      repeat (2) @(negedge clk);
      reset = 1'b0;

      checkOutput("reset_y", y, 0);
      checkOutput("reset_valid", y_valid, 0);
      checkOutput("reset_ovf", ovf, 0);

      // Four phases of one symbol
      loadBasic();
      clearGot();
      runBurst(4);
      exp = '{1024, 2048, 3072, 4095};
      checkSeq("phases", exp, 4);
      if (gotCyc.size() == 4) checkOutput("phases_b2b", gotCyc[3] - gotCyc[0], 3);

      // Phase counter wraps after L strobes
      loadBasic();
      clearGot();
      runBurst(5);
      checkOutput("wrap_count", gotY.size(), 5);
      if (gotY.size() == 5) checkOutput("wrap_5th", gotY[4], 1024);

      // Saturation both ways
      doReset();
      for (int i = 0; i < N; i++) applyStimulus(0, 0, 0, 0, 1, i, 131071);
      repeat (5) applyStimulus(1, 0, 131071, 0, 0, 0, 0);
      clearGot();
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      idle(3);
      checkOutput("satpos_count", gotY.size(), 1);
      if (gotY.size() == 1) begin
         checkOutput("satpos_y", gotY[0], 131071);
         checkOutput("satpos_ovf", gotOvf[0], 1);
      end
      repeat (5) applyStimulus(1, 0, -131072, 0, 0, 0, 0);
      clearGot();
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      idle(3);
      checkOutput("satneg_count", gotY.size(), 1);
      if (gotY.size() == 1) begin
         checkOutput("satneg_y", gotY[0], -131072);
         checkOutput("satneg_ovf", gotOvf[0], 1);
      end

      // Bypass: zero-order hold on back-to-back strobes
      clearGot();
      applyStimulus(1, 0, -500, 1, 0, 0, 0);
      repeat (3) applyStimulus(0, 1, 0, 1, 0, 0, 0);
      idle(3);
      exp = '{-500, -500, -500};
      checkSeq("bypass", exp, 3);
      if (gotCyc.size() == 3) checkOutput("bypass_b2b", gotCyc[2] - gotCyc[0], 2);

      // Out-of-range write ignored; coincident write uses old coefficient
      loadBasic();
      applyStimulus(0, 0, 0, 0, 1, 20, 1000);
      clearGot();
      applyStimulus(1, 1, 4096, 0, 1, 0, 0);
      idle(1);
      applyStimulus(1, 1, 4096, 0, 0, 0, 0);
      idle(3);
      exp = '{1024, 0};
      checkSeq("coefwr", exp, 2);

      // Reset right after a strobe discards it and clears coefficients
      loadBasic();
      clearGot();
      applyStimulus(1, 1, 4096, 0, 0, 0, 0);
      doReset();
      idle(2);
      checkOutput("rstflight_count", gotY.size(), 0);
      checkOutput("rstflight_y", y, 0);
      checkOutput("rstflight_ovf", ovf, 0);
      clearGot();
      runBurst(4);
      exp = '{0, 0, 0, 0};
      checkSeq("rstcoef", exp, 4);

      // Randomized traffic against the reference model
      doReset();
      for (int i = 0; i < N; i++) applyStimulus(0, 0, 0, 0, 1, i,
         longint'($urandom_range(0, 4095)) - 2048);
      for (int c = 0; c < 1500; c++) begin
         longint xr;
         longint dr;
         xr = longint'($urandom_range(0, 262143)) - 131072;
         dr = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 4095)) - 2048
                                         : longint'($urandom_range(0, 262143)) - 131072;
         reset = ($urandom_range(0, 199) == 0);
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, xr,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                       int'($urandom_range(0, 31)), dr);
      end
      reset = 1'b0;
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/upsampler_poly.md
UPSAMPLER_POLY -- requirements
Module: upsampler_poly

Interface
REQ-001 Parameters (name, default, meaning): DW, 18, signed data width in/out.
REQ-002 CW, 18, signed coefficient width.
REQ-003 L, 4, upsample factor (phases), ≥2.
REQ-004 TPP, 5, taps per phase; total taps N = L*TPP.
REQ-005 OUT_SHIFT, 17, arithmetic right shift applied to accumulator before saturation.
REQ-006 Ports: clk  in  1  system clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 sym_clk_ena  in  1  input-rate strobe; x_in accepted this cycle.
REQ-009 sam_clk_ena  in  1  output-rate strobe; one output computed per strobe.
REQ-010 x_in  in  DW  signed input sample.
REQ-011 bypass  in  1  1 = zero-order-hold mode, no filtering.
REQ-012 coef_wr_en  in  1  coefficient write strobe.
REQ-013 coef_addr  in  clog2(N)  coefficient index.
REQ-014 coef_data  in  CW  signed coefficient value.
REQ-015 y  out  DW  signed filtered output, registered.
REQ-016 y_valid  out  1  one-cycle pulse marking a new y.
REQ-017 ovf  out  1  high with y_valid when that y was saturated.

Function
REQ-018 Delay line x[0..TPP-1] shall shift on sym_clk_ena: x[0] <= x_in, x[k] <= x[k-1]; held otherwise.
REQ-019 Phase counter p shall load 0 on sym_clk_ena and increment by 1 on each sam_clk_ena without sym_clk_ena; L-1 wraps to 0.
REQ-020 Same-cycle sym_clk_ena and sam_clk_ena: output shall use the new x_in as x[0] and phase 0; p becomes 1 afterwards.
REQ-021 Per sam_clk_ena: acc = sum over k=0..TPP-1 of h[k*L+p] * x[k], full precision, width DW+CW+clog2(TPP), no wrap.
REQ-022 Output value = acc >>> OUT_SHIFT (floor), saturated to DW signed range [-2^(DW-1), 2^(DW-1)-1]; ovf = 1 iff clipping occurred.
REQ-023 Pipeline: products registered on clk after strobe cycle T; sum/saturate registered at T+2; y, ovf, y_valid update at T+2 (latency 2 clk).
REQ-024 Back-to-back sam_clk_ena on consecutive cycles shall yield consecutive y_valid pulses, none dropped.
REQ-025 y and ovf hold value between y_valid pulses; y_valid high exactly one cycle per strobe.
REQ-026 bypass=1: output for a strobe = x[0] (after REQ-020 update), same latency, ovf=0; filter state continues updating.
REQ-027 Coefficient write: h[coef_addr] <= coef_data on clk when coef_wr_en; coef_addr ≥ N ignored, no other effect.
REQ-028 Write coincident with sam_clk_ena: that output uses the old coefficient; later strobes use the new one.
REQ-029 Reset not asserted: coefficients never change except via REQ-027.

Reset
REQ-030 reset shall clear x[*], p, pipeline registers, and all h[*] to 0; y=0, y_valid=0, ovf=0 on the cycle following reset assertion.
REQ-031 reset has priority over all strobes and coefficient writes in the same cycle; in-flight outputs are discarded (no y_valid after reset).
REQ-032 Strobes in the first cycle after reset deassertion shall be processed normally.

Verification (defaults)
REQ-033 Load h[0..3]=32768,65536,98304,131071, others 0; sym_clk_ena with x_in=4096, then 4 sam_clk_ena (first coincident) -> y=1024,2048,3072,4095, ovf=0, each 2 clk after its strobe.
REQ-034 All h=131071; 5 symbols x_in=131071 then strobe -> y=131071, ovf=1; repeat with x_in=-131072 -> y=-131072, ovf=1.
REQ-035 Setup of REQ-033, 5 sam_clk_ena after one symbol -> 5th output equals 1st (1024), phase wrapped.
REQ-036 bypass=1, x_in=-500 symbol, 3 strobes on consecutive cycles -> three consecutive y_valid pulses, y=-500, ovf=0.
REQ-037 coef_addr=20 write of 1000 -> no h change; write h[0]=0 coincident with strobe -> that y=1024, next phase-0 y=0.
REQ-038 Assert reset 1 cycle after a strobe -> no y_valid for it; y=0, ovf=0; subsequent REQ-033 outputs all 0 until coefficients reloaded.
